// File: rtl/ddr4_mc_ecc_fi_xor_multi.sv
`default_nettype none
// ============================================================================
// ddr4_mc_ecc_fi_xor_multi - ECC fault-injection XOR stage on the MC write path
// Revision: 1.0
// ============================================================================
module ddr4_mc_ecc_fi_xor_multi #(
    parameter int DQ_WIDTH    = 72,
    parameter int DQS_WIDTH   = 9,
    parameter int DATA_WIDTH  = 64,
    parameter int ECC_WIDTH   = 8,
    parameter int nCK_PER_CLK = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int EN_DLY      = 2,
    parameter int TCQ         = 100
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [2*nCK_PER_CLK*DQ_WIDTH-1:0]     wrdata_in,
    output logic [2*nCK_PER_CLK*DQ_WIDTH-1:0]     wrdata_out,
    input  logic                                  wrdata_en,
    input  logic [DQS_WIDTH-1:0]                  fi_xor_we,
    input  logic [DQ_WIDTH-1:0]                   fi_xor_wrdata,
    input  logic [$clog2(2*nCK_PER_CLK)-1:0]      fi_burst_sel,
    input  logic [1:0]                            fi_mode,
    input  logic [CNT_WIDTH-1:0]                  fi_count,
    input  logic                                  fi_arm,
    input  logic                                  fi_disarm,
    output logic                                  fi_armed,
    output logic                                  fi_inj_pulse,
    output logic [CNT_WIDTH-1:0]                  fi_inj_total
);

    localparam int BEATS      = 2 * nCK_PER_CLK;
    localparam int BEAT_W     = $clog2(BEATS);
    localparam int DQ_PER_DQS = DQ_WIDTH / DQS_WIDTH;
    localparam logic [1:0] MODE_COUNTED = 2'b01;
    localparam logic [1:0] MODE_PERSIST = 2'b10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t                     state;
    logic [DQ_WIDTH-1:0]        pattern;
    logic [CNT_WIDTH-1:0]       remaining;
    logic [BEAT_W-1:0]          burst_reg;
    logic [1:0]                 mode_reg;
    logic                       wr_vld;
    logic                       inj;
    logic [CNT_WIDTH-1:0]       shots_sel;
    logic [BEATS*DQ_WIDTH-1:0]  inj_mask;

    generate
        if (EN_DLY == 0) begin : g_no_dly
            assign wr_vld = wrdata_en;
        end else begin : g_dly
            logic [EN_DLY-1:0] en_pipe;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    en_pipe <= '0;
                end else begin
                    en_pipe[0] <= wrdata_en;
                    for (int i = 1; i < EN_DLY; i++) begin
                        en_pipe[i] <= en_pipe[i-1];
                    end
                end
            end
            assign wr_vld = en_pipe[EN_DLY-1];
        end
    endgenerate

    assign fi_armed = (state == ARMED);
    assign inj      = fi_armed & wr_vld & ~fi_disarm & rst;

    // Reserved mode behaves as single shot; a zero count still fires once.
    always_comb begin
        shots_sel = CNT_WIDTH'(1);
        if (fi_mode == MODE_COUNTED && fi_count != '0) begin
            shots_sel = fi_count;
        end
    end

    always_comb begin
        inj_mask = '0;
        if (inj) begin
            inj_mask[burst_reg*DATA_WIDTH +: DATA_WIDTH] = pattern[DATA_WIDTH-1:0];
            inj_mask[BEATS*DATA_WIDTH + burst_reg*ECC_WIDTH +: ECC_WIDTH] =
                pattern[DATA_WIDTH +: ECC_WIDTH];
        end
    end

    assign wrdata_out = wrdata_in ^ inj_mask;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            pattern      <= '0;
            remaining    <= '0;
            burst_reg    <= '0;
            mode_reg     <= '0;
            fi_inj_pulse <= 1'b0;
            fi_inj_total <= '0;
        end else begin
            fi_inj_pulse <= inj;
            if (inj && fi_inj_total != '1) begin
                fi_inj_total <= fi_inj_total + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fi_arm && !fi_disarm) begin
                        state     <= ARMED;
                        burst_reg <= fi_burst_sel;
                        mode_reg  <= fi_mode;
                        remaining <= shots_sel;
                    end
                end
                ARMED: begin
                    if (fi_disarm) begin
                        state <= IDLE;
                    end else if (fi_arm) begin
                        burst_reg <= fi_burst_sel;
                        mode_reg  <= fi_mode;
                        remaining <= shots_sel;
                    end else if (inj && mode_reg != MODE_PERSIST) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_WIDTH'(1)) begin
                            state   <= IDLE;
                            pattern <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Loads come last so a pattern written during the final shot survives the clear.
            for (int i = 0; i < DQS_WIDTH; i++) begin
                if (fi_xor_we[i]) begin
                    pattern[i*DQ_PER_DQS +: DQ_PER_DQS] <= fi_xor_wrdata[i*DQ_PER_DQS +: DQ_PER_DQS];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr4_mc_ecc_fi_xor_multi.sv
`default_nettype none
// ============================================================================
// tb_ddr4_mc_ecc_fi_xor_multi - randomized bench against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_ddr4_mc_ecc_fi_xor_multi;

    localparam int DQ     = 72;
    localparam int BEATS  = 8;
    localparam int DW     = 64;
    localparam int EW     = 8;
    localparam int EN_DLY = 2;
    localparam int W      = BEATS * DQ;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  dout, dout2;
    logic          en = 1'b0;
    logic [8:0]    we = '0;
    logic [DQ-1:0] xwd = '0;
    logic [2:0]    sel = '0;
    logic [1:0]    mode = '0;
    logic [7:0]    cnt = '0;
    logic          arm = 1'b0, disarm = 1'b0;
    logic          armed, pulse, armed2, pulse2;
    logic [7:0]    total;
    logic [1:0]    total2;

    ddr4_mc_ecc_fi_xor_multi dut (
        .clk(clk), .rst(rst), .wrdata_in(din), .wrdata_out(dout), .wrdata_en(en),
        .fi_xor_we(we), .fi_xor_wrdata(xwd), .fi_burst_sel(sel), .fi_mode(mode),
        .fi_count(cnt), .fi_arm(arm), .fi_disarm(disarm), .fi_armed(armed),
        .fi_inj_pulse(pulse), .fi_inj_total(total)
    );

    ddr4_mc_ecc_fi_xor_multi #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .wrdata_in(din), .wrdata_out(dout2), .wrdata_en(en),
        .fi_xor_we(we), .fi_xor_wrdata(xwd), .fi_burst_sel(sel), .fi_mode(mode),
        .fi_count(cnt[1:0]), .fi_arm(arm), .fi_disarm(disarm), .fi_armed(armed2),
        .fi_inj_pulse(pulse2), .fi_inj_total(total2)
    );

    // Behavioural model state
    bit            m_armed, m_persist, m_pulse, m_inj;
    int            m_beat, m_left, m_total, m_total2;
    logic [DQ-1:0] m_pat;
    bit            hist [EN_DLY];
    logic [W-1:0]  exp_out, cur_in, last_xor;

    int n_cmp = 0, n_fail = 0;
    int step_diff, n_corrupt, n_pulse;

    function automatic logic [W-1:0] corrupt(input logic [W-1:0] d, input logic [DQ-1:0] p, input int b);
        logic [W-1:0] r;
        r = d;
        for (int k = 0; k < DW; k++) r[b*DW + k] ^= p[k];
        for (int k = 0; k < EW; k++) r[BEATS*DW + b*EW + k] ^= p[DW + k];
        return r;
    endfunction

    task automatic model_latch();
        m_armed   = 1'b1;
        m_beat    = int'(sel);
        m_persist = (mode == 2'd2);
        m_left    = (mode == 2'd1) ? ((cnt == 8'd0) ? 1 : int'(cnt)) : 1;
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            m_armed = 0; m_persist = 0; m_pulse = 0; m_beat = 0; m_left = 0;
            m_total = 0; m_total2 = 0; m_pat = '0;
            for (int i = 0; i < EN_DLY; i++) hist[i] = 0;
        end else begin
            if (m_inj) begin
                m_total  = (m_total  < 255) ? m_total  + 1 : 255;
                m_total2 = (m_total2 < 3)   ? m_total2 + 1 : 3;
            end
            m_pulse = m_inj;
            if (m_armed) begin
                if (disarm)                      m_armed = 0;
                else if (arm)                    model_latch();
                else if (m_inj && !m_persist) begin
                    m_left--;
                    if (m_left == 0) begin m_armed = 0; m_pat = '0; end
                end
            end else if (arm && !disarm) begin
                model_latch();
            end
            for (int i = 0; i < 9; i++) if (we[i]) m_pat[i*8 +: 8] = xwd[i*8 +: 8];
            for (int i = EN_DLY-1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = en;
        end
        @(negedge clk);
    endtask

    // One fabric cycle: random write data, predict, sample, advance model.
    task automatic step();
        for (int i = 0; i < W/32; i++) din[i*32 +: 32] = $urandom;
        m_inj   = m_armed && hist[EN_DLY-1] && !disarm && rst;
        exp_out = m_inj ? corrupt(din, m_pat, m_beat) : din;
        #1;
        cur_in = din;
        if (dout !== exp_out || dout2 !== exp_out) step_diff++;
        if (dout !== din) begin n_corrupt++; last_xor = dout ^ din; end
        advance();
        if (armed !== m_armed || armed2 !== m_armed || pulse !== m_pulse || pulse2 !== m_pulse ||
            total !== 8'(m_total) || total2 !== 2'(m_total2)) step_diff++;
        if (pulse === 1'b1) n_pulse++;
    endtask

    task automatic clr();
        step_diff = 0; n_corrupt = 0; n_pulse = 0; last_xor = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0; step(); rst = 1'b1;
    endtask

    task automatic load(input logic [8:0] w, input logic [DQ-1:0] d);
        we = w; xwd = d; step(); we = '0;
    endtask

    task automatic do_arm(input logic [2:0] s, input logic [1:0] md, input logic [7:0] c);
        sel = s; mode = md; cnt = c; arm = 1'b1; step(); arm = 1'b0;
    endtask

    task automatic writes(input int n, input int disarm_at);
        for (int c = 0; c < n + 4; c++) begin
            en = (c < n); disarm = (c == disarm_at); step();
        end
        en = 1'b0; disarm = 1'b0;
    endtask

    function automatic logic [DQ-1:0] rnd_pat();
        logic [DQ-1:0] p;
        p = {$urandom, $urandom, $urandom};
        p[0] = 1'b1;
        return p;
    endfunction

    task automatic test_reset();
        clr();
        rst = 1'b0; arm = 1'b1; en = 1'b1; sel = 3'd5; mode = 2'd2;
        repeat (3) step();
        arm = 1'b0; en = 1'b0; rst = 1'b1;
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed: got %b want 0", armed); end
        n_cmp++; if (total !== 8'd0) begin n_fail++; $display("FAIL reset_total: got %0d want 0", total); end
        n_cmp++; if (total2 !== 2'd0) begin n_fail++; $display("FAIL reset_total2: got %0d want 0", total2); end
        n_cmp++; if (n_corrupt !== 0) begin n_fail++; $display("FAIL reset_passthru: got %0d altered want 0", n_corrupt); end
        n_cmp++; if (step_diff !== 0) begin n_fail++; $display("FAIL reset_model: got %0d diffs want 0", step_diff); end
    endtask

    task automatic test_single();
        logic [W-1:0] exp_x;
        exp_x = '0; exp_x[3*DW] = 1'b1; exp_x[BEATS*DW + 3*EW] = 1'b1;
        do_reset(); clr();
        load(9'h1FF, 72'h01_0000_0000_0000_0001);
        do_arm(3'd3, 2'd0, 8'd0);
        n_cmp++; if (armed !== 1'b1) begin n_fail++; $display("FAIL single_armed: got %b want 1", armed); end
        writes(1, -1);
        n_cmp++; if (n_corrupt !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", n_corrupt); end
        n_cmp++; if (last_xor !== exp_x) begin n_fail++; $display("FAIL single_xor: got %h want %h", last_xor, exp_x); end
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL single_disarmed: got %b want 0", armed); end
        n_corrupt = 0;
        writes(1, -1);
        n_cmp++; if (n_corrupt !== 0) begin n_fail++; $display("FAIL single_second: got %0d want 0", n_corrupt); end
        n_cmp++; if (total !== 8'd1) begin n_fail++; $display("FAIL single_total: got %0d want 1", total); end
        n_cmp++; if (step_diff !== 0) begin n_fail++; $display("FAIL single_model: got %0d diffs want 0", step_diff); end
    endtask

    task automatic test_counted();
        do_reset(); clr();
        load(9'h1FF, rnd_pat());
        do_arm(3'($urandom_range(0, 7)), 2'd1, 8'd3);
        writes(5, -1);
        n_cmp++; if (n_corrupt !== 3) begin n_fail++; $display("FAIL counted3_inj: got %0d want 3", n_corrupt); end
        n_cmp++; if (n_pulse !== 3) begin n_fail++; $display("FAIL counted3_pulse: got %0d want 3", n_pulse); end
        n_cmp++; if (total !== 8'd3) begin n_fail++; $display("FAIL counted3_total: got %0d want 3", total); end
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL counted3_armed: got %b want 0", armed); end
        n_corrupt = 0;
        load(9'h1FF, rnd_pat());
        do_arm(3'($urandom_range(0, 7)), 2'd1, 8'd0);
        writes(3, -1);
        n_cmp++; if (n_corrupt !== 1) begin n_fail++; $display("FAIL counted0_inj: got %0d want 1", n_corrupt); end
        n_cmp++; if (total !== 8'd4) begin n_fail++; $display("FAIL counted0_total: got %0d want 4", total); end
        n_cmp++; if (step_diff !== 0) begin n_fail++; $display("FAIL counted_model: got %0d diffs want 0", step_diff); end
    endtask

    task automatic test_persistent();
        logic [DQ-1:0] p;
        logic [2:0]    s;
        p = rnd_pat(); s = 3'($urandom_range(0, 7));
        do_reset(); clr();
        load(9'h1FF, p);
        do_arm(s, 2'd2, 8'd0);
        writes(5, 6);
        n_cmp++; if (n_corrupt !== 4) begin n_fail++; $display("FAIL persist_inj: got %0d want 4", n_corrupt); end
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL persist_disarm: got %b want 0", armed); end
        n_cmp++; if (total !== 8'd4) begin n_fail++; $display("FAIL persist_total: got %0d want 4", total); end
        n_corrupt = 0;
        do_arm(s, 2'd0, 8'd0);
        writes(1, -1);
        n_cmp++; if (last_xor !== corrupt('0, p, int'(s))) begin n_fail++; $display("FAIL persist_kept: got %h want %h", last_xor, corrupt('0, p, int'(s))); end
        n_cmp++; if (step_diff !== 0) begin n_fail++; $display("FAIL persist_model: got %0d diffs want 0", step_diff); end
    endtask

    task automatic test_collision();
        logic [DQ-1:0] a, b, c, p1, p2;
        logic [2:0]    s;
        a = rnd_pat(); b = rnd_pat(); s = 3'($urandom_range(0, 7));
        p1 = a; p1[7:0] = b[7:0];
        c = rnd_pat(); c[71:64] = ~p1[71:64];
        p2 = p1; p2[71:64] = c[71:64];
        do_reset(); clr();
        load(9'h1FF, a);
        load(9'h001, b);
        do_arm(s, 2'd2, 8'd0);
        en = 1'b1; step(); en = 1'b0; step();
        we = 9'h100; xwd = c; step(); we = '0;
        n_cmp++; if (last_xor !== corrupt('0, p1, int'(s))) begin n_fail++; $display("FAIL collide_old: got %h want %h", last_xor, corrupt('0, p1, int'(s))); end
        disarm = 1'b1; step(); disarm = 1'b0;
        do_arm(s, 2'd0, 8'd0);
        writes(1, -1);
        n_cmp++; if (last_xor !== corrupt('0, p2, int'(s))) begin n_fail++; $display("FAIL collide_new: got %h want %h", last_xor, corrupt('0, p2, int'(s))); end
        n_cmp++; if (step_diff !== 0) begin n_fail++; $display("FAIL collide_model: got %0d diffs want 0", step_diff); end
    endtask

    task automatic test_saturation();
        do_reset(); clr();
        load(9'h1FF, rnd_pat());
        do_arm(3'($urandom_range(0, 7)), 2'd2, 8'd0);
        writes(6, -1);
        n_cmp++; if (total2 !== 2'd3) begin n_fail++; $display("FAIL sat_total2: got %0d want 3", total2); end
        n_cmp++; if (total !== 8'd6) begin n_fail++; $display("FAIL sat_total: got %0d want 6", total); end
        n_cmp++; if (armed !== 1'b1) begin n_fail++; $display("FAIL sat_armed: got %b want 1", armed); end
        n_corrupt = 0;
        en = 1'b1; step(); en = 1'b0; step();
        rst = 1'b0; step(); rst = 1'b1;
        n_cmp++; if (n_corrupt !== 0) begin n_fail++; $display("FAIL rst_midarm_out: got %0d altered want 0", n_corrupt); end
        n_cmp++; if (armed !== 1'b0 || total !== 8'd0) begin n_fail++; $display("FAIL rst_midarm_state: got armed=%b total=%0d want 0/0", armed, total); end
        n_cmp++; if (step_diff !== 0) begin n_fail++; $display("FAIL sat_model: got %0d diffs want 0", step_diff); end
    endtask

    task automatic test_back_to_back();
        do_reset(); clr();
        for (int c = 0; c < 400; c++) begin
            en     = ($urandom_range(0, 2) != 0);
            arm    = ($urandom_range(0, 11) == 0);
            disarm = ($urandom_range(0, 19) == 0);
            we     = ($urandom_range(0, 5) == 0) ? 9'($urandom) : 9'd0;
            xwd    = {$urandom, $urandom, $urandom};
            sel    = 3'($urandom);
            mode   = 2'($urandom);
            cnt    = 8'($urandom_range(0, 3));
            step();
        end
        en = 1'b0; arm = 1'b0; disarm = 1'b0; we = '0;
        n_cmp++; if (step_diff !== 0) begin n_fail++; $display("FAIL random_model: got %0d diffs want 0", step_diff); end
        n_cmp++; if (n_pulse !== m_total) begin n_fail++; $display("FAIL random_pulses: got %0d want %0d", n_pulse, m_total); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_counted();
        test_persistent();
        test_collision();
        test_saturation();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
